// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared size encodings, FSM states and alignment helper for the MEM stage
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {IDLE, BUSY} state_t;

    // Bytes never fault; halves need a[0]==0; words (and size 11) need a[1:0]==0
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? a[0] : |a;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: req/ack data bus between the MEM stage and data RAM / I/O
interface mem_stage_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, mem_be, output mem_ack, mem_rdata);

endinterface

// File: rtl/mem_stage_align.sv
// mem_stage_align: store lane/byte-enable generation and load lane extraction with extension
module mem_stage_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_a,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_a,
    input  logic        ld_uns,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  b;
    logic [15:0] h;

    // Little-endian lanes; size 11 falls through to the word case
    always_comb begin
        b       = rdata[{ld_a, 3'b000} +: 8];
        h       = ld_a[1] ? rdata[31:16] : rdata[15:0];
        be      = st_size == SZ_BYTE ? 4'b0001 << st_a : st_size == SZ_HALF ? (st_a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata   = st_size == SZ_BYTE ? {4{st_data[7:0]}} : st_size == SZ_HALF ? {2{st_data[15:0]}} : st_data;
        ld_data = ld_size == SZ_BYTE ? {{24{b[7] & ~ld_uns}}, b} :
                  ld_size == SZ_HALF ? {{16{h[15] & ~ld_uns}}, h} : rdata;
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage doing load/store over a req/ack bus and driving the MEM/WB latch
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_load_uns,
    input  logic        ex_MemIOtoReg,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_wreg,
    mem_stage_if.master bus,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_ALU_result,
    output logic        wb_MemIOtoReg,
    output logic        wb_reg_write,
    output logic [4:0]  wb_wreg,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_bus,
    output logic [31:0] exc_badvaddr
);

    localparam int CW = $clog2(TIMEOUT);

    state_t      state;
    logic [CW-1:0] cnt;
    logic        flushed;
    logic [31:0] p_alu;
    logic [1:0]  p_size;
    logic        p_uns, p_read, p_memio, p_regw;
    logic [4:0]  p_wreg;
    logic [3:0]  be;
    logic [31:0] wdata, ld_data;
    logic        accept, is_mem, mis;

    mem_stage_align u_align (
        .st_size (ex_mem_size),
        .st_a    (ex_alu_result[1:0]),
        .st_data (ex_store_data),
        .be      (be),
        .wdata   (wdata),
        .ld_size (p_size),
        .ld_a    (p_alu[1:0]),
        .ld_uns  (p_uns),
        .rdata   (bus.mem_rdata),
        .ld_data (ld_data)
    );

    assign accept = ex_valid & ~flush;
    assign is_mem = ex_mem_read | ex_mem_write;
    assign mis    = misaligned(ex_mem_size, ex_alu_result[1:0]);
    assign stall  = (state == BUSY) & ~bus.mem_ack;

    // IDLE accepts from EX; BUSY holds the bus until ack or timeout, then writes the MEM/WB latch
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            flushed       <= 1'b0;
            p_alu         <= '0;
            p_size        <= '0;
            p_uns         <= 1'b0;
            p_read        <= 1'b0;
            p_memio       <= 1'b0;
            p_regw        <= 1'b0;
            p_wreg        <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            wb_valid      <= 1'b0;
            wb_read_data  <= '0;
            wb_ALU_result <= '0;
            wb_MemIOtoReg <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_wreg       <= '0;
            exc_adel      <= 1'b0;
            exc_ades      <= 1'b0;
            exc_bus       <= 1'b0;
            exc_badvaddr  <= '0;
        end else begin
            exc_adel     <= 1'b0;
            exc_ades     <= 1'b0;
            exc_bus      <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            if (state == IDLE) begin
                if (accept && !is_mem) begin
                    wb_valid      <= 1'b1;
                    wb_read_data  <= '0;
                    wb_ALU_result <= ex_alu_result;
                    wb_MemIOtoReg <= ex_MemIOtoReg;
                    wb_reg_write  <= ex_reg_write;
                    wb_wreg       <= ex_wreg;
                end else if (accept && mis) begin
                    exc_adel     <= ex_mem_read;
                    exc_ades     <= ~ex_mem_read;
                    exc_badvaddr <= ex_alu_result;
                end else if (accept) begin
                    state         <= BUSY;
                    cnt           <= '0;
                    flushed       <= 1'b0;
                    bus.mem_req   <= 1'b1;
                    bus.mem_we    <= ex_mem_write & ~ex_mem_read;
                    bus.mem_addr  <= {ex_alu_result[31:2], 2'b00};
                    bus.mem_wdata <= wdata;
                    bus.mem_be    <= be;
                    p_alu         <= ex_alu_result;
                    p_size        <= ex_mem_size;
                    p_uns         <= ex_load_uns;
                    p_read        <= ex_mem_read;
                    p_memio       <= ex_MemIOtoReg;
                    p_regw        <= ex_reg_write;
                    p_wreg        <= ex_wreg;
                end
            end else if (bus.mem_ack) begin
                state         <= IDLE;
                bus.mem_req   <= 1'b0;
                wb_valid      <= ~(flushed | flush);
                wb_reg_write  <= p_regw & ~(flushed | flush);
                wb_read_data  <= p_read ? ld_data : '0;
                wb_ALU_result <= p_alu;
                wb_MemIOtoReg <= p_memio;
                wb_wreg       <= p_wreg;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
                state        <= IDLE;
                bus.mem_req  <= 1'b0;
                exc_bus      <= 1'b1;
                exc_badvaddr <= p_alu;
            end else begin
                cnt     <= cnt + 1'b1;
                flushed <= flushed | flush;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for the MEM stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clock = 0, reset = 1, flush = 0, ex_valid = 0;
    logic [31:0] ex_alu_result = 0, ex_store_data = 0;
    logic        ex_mem_read = 0, ex_mem_write = 0, ex_load_uns = 0, ex_MemIOtoReg = 0, ex_reg_write = 0;
    logic [1:0]  ex_mem_size = 0;
    logic [4:0]  ex_wreg = 0;
    logic        stall, wb_valid, wb_MemIOtoReg, wb_reg_write, exc_adel, exc_ades, exc_bus;
    logic [31:0] wb_read_data, wb_ALU_result, exc_badvaddr;
    logic [4:0]  wb_wreg;
    int          vectors = 0, errors = 0;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .flush(flush), .ex_valid(ex_valid),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
        .ex_load_uns(ex_load_uns), .ex_MemIOtoReg(ex_MemIOtoReg), .ex_reg_write(ex_reg_write),
        .ex_wreg(ex_wreg), .bus(bus), .stall(stall), .wb_valid(wb_valid),
        .wb_read_data(wb_read_data), .wb_ALU_result(wb_ALU_result), .wb_MemIOtoReg(wb_MemIOtoReg),
        .wb_reg_write(wb_reg_write), .wb_wreg(wb_wreg), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .exc_bus(exc_bus), .exc_badvaddr(exc_badvaddr)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic set_ex(input logic rd, input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] sd);
        ex_valid = 1; ex_alu_result = a; ex_store_data = sd; ex_mem_read = rd; ex_mem_write = wr;
        ex_mem_size = sz; ex_load_uns = uns; ex_MemIOtoReg = rd; ex_reg_write = ~wr; ex_wreg = 5'd7;
    endtask

    task automatic test_reset;
        reset = 1; bus.mem_ack = 0; bus.mem_rdata = 0;
        step; step;
        vectors++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
        vectors++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", bus.mem_req); end
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        vectors++; if (exc_badvaddr !== 32'h0) begin errors++; $display("FAIL reset_badvaddr got %h exp 0", exc_badvaddr); end
        reset = 0;
        step;
    endtask

    task automatic test_alu;
        set_ex(0, 0, SZ_WORD, 0, 32'h1234, 0);
        ex_wreg = 5'd5;
        step;
        ex_valid = 0;
        vectors++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wb_valid got %b exp 1", wb_valid); end
        vectors++; if (wb_ALU_result !== 32'h1234) begin errors++; $display("FAIL alu_result got %h exp 00001234", wb_ALU_result); end
        vectors++; if (wb_reg_write !== 1'b1 || wb_wreg !== 5'd5) begin errors++; $display("FAIL alu_regw got %b/%0d exp 1/5", wb_reg_write, wb_wreg); end
        vectors++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL alu_no_req got %b exp 0", bus.mem_req); end
        step;
        vectors++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0) begin errors++; $display("FAIL alu_bubble got %b/%b exp 0/0", wb_valid, wb_reg_write); end
    endtask

    task automatic test_access(input string nm, input logic rd, input logic [1:0] sz, input logic uns,
                               input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat, input int waits,
                               input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
        int st = 0;
        set_ex(rd, ~rd, sz, uns, a, sd);
        step;
        ex_valid = 0;
        vectors++; if (bus.mem_req !== 1'b1 || bus.mem_we !== ~rd) begin errors++; $display("FAIL %s_req got req=%b we=%b exp 1/%b", nm, bus.mem_req, bus.mem_we, ~rd); end
        vectors++; if (bus.mem_addr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL %s_addr got %h exp %h", nm, bus.mem_addr, {a[31:2], 2'b00}); end
        if (!rd) begin
            vectors++; if (bus.mem_be !== ebe) begin errors++; $display("FAIL %s_be got %b exp %b", nm, bus.mem_be, ebe); end
            vectors++; if (bus.mem_wdata !== ewd) begin errors++; $display("FAIL %s_wdata got %h exp %h", nm, bus.mem_wdata, ewd); end
        end
        repeat (waits) begin
            st += int'(stall);
            step;
        end
        bus.mem_ack = 1; bus.mem_rdata = rdat;
        #1;
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL %s_ack_stall got %b exp 0", nm, stall); end
        vectors++; if (st != waits) begin errors++; $display("FAIL %s_stall_cycles got %0d exp %0d", nm, st, waits); end
        step;
        bus.mem_ack = 0;
        vectors++; if (wb_valid !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL %s_done got valid=%b req=%b exp 1/0", nm, wb_valid, bus.mem_req); end
        vectors++; if (wb_read_data !== (rd ? erd : 32'h0)) begin errors++; $display("FAIL %s_rdata got %h exp %h", nm, wb_read_data, rd ? erd : 32'h0); end
        vectors++; if (wb_ALU_result !== a || wb_reg_write !== rd) begin errors++; $display("FAIL %s_wb got %h/%b exp %h/%b", nm, wb_ALU_result, wb_reg_write, a, rd); end
        step;
    endtask

    task automatic test_misalign;
        set_ex(1, 0, SZ_WORD, 0, 32'h6, 0);
        step;
        ex_valid = 0;
        vectors++; if (exc_adel !== 1'b1 || exc_ades !== 1'b0) begin errors++; $display("FAIL adel_pulse got %b/%b exp 1/0", exc_adel, exc_ades); end
        vectors++; if (exc_badvaddr !== 32'h6) begin errors++; $display("FAIL adel_badvaddr got %h exp 00000006", exc_badvaddr); end
        vectors++; if (bus.mem_req !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL adel_quiet got req=%b valid=%b exp 0/0", bus.mem_req, wb_valid); end
        step;
        vectors++; if (exc_adel !== 1'b0 || bus.mem_req !== 1'b0 || exc_badvaddr !== 32'h6) begin errors++; $display("FAIL adel_after got %b/%b/%h exp 0/0/00000006", exc_adel, bus.mem_req, exc_badvaddr); end
        set_ex(0, 1, SZ_HALF, 0, 32'h2005, 0);
        step;
        ex_valid = 0;
        vectors++; if (exc_ades !== 1'b1 || exc_adel !== 1'b0 || exc_badvaddr !== 32'h2005) begin errors++; $display("FAIL ades got %b/%b/%h exp 1/0/00002005", exc_ades, exc_adel, exc_badvaddr); end
        vectors++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL ades_req got %b exp 0", bus.mem_req); end
        step;
    endtask

    task automatic test_timeout;
        int n = 0;
        bit seen = 0;
        set_ex(1, 0, SZ_WORD, 0, 32'h3000, 0);
        step;
        ex_valid = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step;
            n++;
            if (exc_bus) seen = 1;
        end
        vectors++; if (n != 16) begin errors++; $display("FAIL timeout_cycles got %0d exp 16", n); end
        vectors++; if (stall !== 1'b0 || bus.mem_req !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL timeout_idle got stall=%b req=%b valid=%b exp 0/0/0", stall, bus.mem_req, wb_valid); end
        vectors++; if (exc_badvaddr !== 32'h3000) begin errors++; $display("FAIL timeout_badvaddr got %h exp 00003000", exc_badvaddr); end
        step;
        vectors++; if (exc_bus !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b exp 0", exc_bus); end
    endtask

    task automatic test_flush;
        set_ex(1, 0, SZ_WORD, 0, 32'h4000, 0);
        step;
        ex_valid = 0;
        flush = 1;
        step;
        flush = 0;
        vectors++; if (bus.mem_req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL flush_no_abort got req=%b stall=%b exp 1/1", bus.mem_req, stall); end
        step;
        bus.mem_ack = 1; bus.mem_rdata = 32'hCAFE_F00D;
        step;
        bus.mem_ack = 0;
        vectors++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL flush_busy got valid=%b regw=%b req=%b exp 0/0/0", wb_valid, wb_reg_write, bus.mem_req); end
        set_ex(1, 0, SZ_WORD, 0, 32'h4004, 0);
        step;
        ex_valid = 0;
        bus.mem_ack = 1; flush = 1;
        step;
        bus.mem_ack = 0; flush = 0;
        vectors++; if (wb_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL flush_ack_same got valid=%b stall=%b exp 0/0", wb_valid, stall); end
        set_ex(0, 0, SZ_WORD, 0, 32'h99, 0);
        flush = 1;
        step;
        flush = 0; ex_valid = 0;
        vectors++; if (wb_valid !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL flush_idle got valid=%b req=%b exp 0/0", wb_valid, bus.mem_req); end
        step;
    endtask

    task automatic test_reset_busy;
        set_ex(1, 0, SZ_WORD, 0, 32'h5000, 0);
        step;
        ex_valid = 0;
        vectors++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstbusy_pre got %b exp 1", bus.mem_req); end
        reset = 1;
        step;
        vectors++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rstbusy_bus got req=%b stall=%b exp 0/0", bus.mem_req, stall); end
        vectors++; if (wb_valid !== 1'b0 || wb_read_data !== 32'h0 || wb_ALU_result !== 32'h0 || wb_reg_write !== 1'b0 || wb_wreg !== 5'd0 || wb_MemIOtoReg !== 1'b0)
            begin errors++; $display("FAIL rstbusy_wb got %b/%h/%h/%b/%0d/%b exp all 0", wb_valid, wb_read_data, wb_ALU_result, wb_reg_write, wb_wreg, wb_MemIOtoReg); end
        reset = 0;
        step;
    endtask

    initial begin
        test_reset;
        test_alu;
        test_access("lb",  1, SZ_BYTE, 0, 32'h1003, 32'h0,        32'h80FF_FFFF, 3, 4'b0000, 32'h0,        32'hFFFF_FF80);
        test_access("lbu", 1, SZ_BYTE, 1, 32'h1003, 32'h0,        32'h80FF_FFFF, 3, 4'b0000, 32'h0,        32'h0000_0080);
        test_access("lh",  1, SZ_HALF, 0, 32'h0002, 32'h0,        32'h8001_1234, 1, 4'b0000, 32'h0,        32'hFFFF_8001);
        test_access("lhu", 1, SZ_HALF, 1, 32'h0000, 32'h0,        32'h8001_9234, 0, 4'b0000, 32'h0,        32'h0000_9234);
        test_access("lw",  1, SZ_WORD, 0, 32'h0008, 32'h0,        32'h8765_4321, 2, 4'b0000, 32'h0,        32'h8765_4321);
        test_access("sh",  0, SZ_HALF, 0, 32'h2002, 32'h1234_ABCD, 32'h0,        0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        test_access("sb",  0, SZ_BYTE, 0, 32'h2001, 32'h0000_005A, 32'h0,        1, 4'b0010, 32'h5A5A_5A5A, 32'h0);
        test_access("sw",  0, SZ_WORD, 0, 32'h2008, 32'hDEAD_BEEF, 32'h0,        2, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        test_misalign;
        test_timeout;
        test_flush;
        test_reset_busy;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
